linked_list_fifo_pop_scheduler: RTL and testbench

Drains the per-queue lists of a `linked_list_fifo` instance onto one downstream valid/ready stream. It tracks per-queue occupancy from the push side and picks a non-empty, enabled queue by round-robin with a bounded burst. It drives the FIFO's `pop`/`pop_fifo` and absorbs the FIFO's one-cycle read latency in an internal output buffer. It sits between the shared linked-list FIFO and the single consumer that serves all queues.

---
 rtl/llf_pkg.sv | 27 ++
 rtl/llf_sched_out_buf.sv | 57 +++++
 rtl/linked_list_fifo_pop_scheduler.sv | 156 +++++++++++++++
 tb/tb_linked_list_fifo_pop_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llf_pkg.sv
// Shared definitions for the linked-list FIFO family: output buffer sizing
// and the bit-width helper used to size queue ids and pointers.
package llf_pkg;

    // Entries the pop scheduler may have outstanding (buffered plus in flight).
    localparam int OUT_BUF_DEPTH = 3;
    localparam int OUT_BUF_CNT_W = 2;

    typedef logic [OUT_BUF_CNT_W-1:0] buf_ptr_t;

    // Number of bits needed to represent 'value' (at least 1).
    function automatic int log2(input int value);
        int bits = 1;
        for (int i = 1; i < 31; i++) begin
            if (value >= (1 << i)) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

    // Advance a buffer pointer modulo OUT_BUF_DEPTH.
    function automatic buf_ptr_t buf_ptr_inc(input buf_ptr_t ptr);
        return (ptr == buf_ptr_t'(OUT_BUF_DEPTH - 1)) ? '0 : ptr + buf_ptr_t'(1);
    endfunction

endpackage

// File: rtl/llf_sched_out_buf.sv
// Small in-order {queue id, data} buffer that absorbs the FIFO read latency
// in front of the downstream consumer. Head outputs read as zero when empty.
module llf_sched_out_buf
    import llf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ID_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr,
    input  logic [ID_W-1:0]          wr_id,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd,
    output logic [OUT_BUF_CNT_W-1:0] cnt,
    output logic [WIDTH-1:0]         head_data,
    output logic [ID_W-1:0]          head_id
);

    logic [WIDTH-1:0] data_mem [OUT_BUF_DEPTH];
    logic [ID_W-1:0]  id_mem   [OUT_BUF_DEPTH];
    buf_ptr_t         wr_ptr;
    buf_ptr_t         rd_ptr;

    // Entry storage: written at the tail on every capture.
    // NOTE: storage carries no reset; the count gates visibility, so stale
    // contents after reset are never presented as valid.
    always_ff @(posedge clk) begin
        if (wr) begin
            data_mem[wr_ptr] <= wr_data;
            id_mem[wr_ptr]   <= wr_id;
        end
    end

    // Pointers and occupancy; a simultaneous write and read keep the count.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr) wr_ptr <= buf_ptr_inc(wr_ptr);
            if (rd) rd_ptr <= buf_ptr_inc(rd_ptr);
            case ({wr, rd})
                2'b10:   cnt <= cnt + OUT_BUF_CNT_W'(1);
                2'b01:   cnt <= cnt - OUT_BUF_CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign head_data = (cnt != '0) ? data_mem[rd_ptr] : '0;
    assign head_id   = (cnt != '0) ? id_mem[rd_ptr]   : '0;

endmodule

// File: rtl/linked_list_fifo_pop_scheduler.sv
// Drains the per-queue lists of a shared linked-list FIFO onto one
// valid/ready stream: occupancy tracking, round-robin selection with a
// bounded burst, credit-limited pops and a latency-absorbing output buffer.
module linked_list_fifo_pop_scheduler
    import llf_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int FIFOS      = 8,
    parameter int BURST      = 4,
    parameter int LOG2_FIFOS = log2(FIFOS - 1),
    parameter int LOG2_DEPTH = log2(DEPTH - 1)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                push,
    input  logic [LOG2_FIFOS-1:0]               push_fifo,
    input  logic [FIFOS-1:0]                    q_en,
    output logic                                pop,
    output logic [LOG2_FIFOS-1:0]               pop_fifo,
    input  logic [WIDTH-1:0]                    fifo_q,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WIDTH-1:0]                    out_data,
    output logic [LOG2_FIFOS-1:0]               out_fifo,
    output logic [FIFOS*(LOG2_DEPTH+1)-1:0]     occ
);

    localparam int OCC_W    = LOG2_DEPTH + 1;
    localparam int BURST_W  = $clog2(BURST + 1);
    localparam int CREDIT_W = OUT_BUF_CNT_W + 1;

    logic [OCC_W-1:0]         occ_r [FIFOS];
    logic [FIFOS-1:0]         elig;
    logic [FIFOS-1:0]         push_hit;
    logic [FIFOS-1:0]         pop_hit;
    logic                     any_elig;
    logic                     credit_ok;
    logic                     stay;
    logic                     found;
    logic [LOG2_FIFOS-1:0]    sel;
    logic [LOG2_FIFOS-1:0]    cur;
    logic [BURST_W-1:0]       burst_cnt;
    logic                     inflight;
    logic [LOG2_FIFOS-1:0]    inflight_fifo;
    logic [OUT_BUF_CNT_W-1:0] buf_cnt;

    // (base + offset) modulo FIFOS, for offsets in 1..FIFOS.
    function automatic logic [LOG2_FIFOS-1:0] wrap_add(input logic [LOG2_FIFOS-1:0] base,
                                                        input int offset);
        int sum = int'(base) + offset;
        if (sum >= FIFOS) sum -= FIFOS;
        return LOG2_FIFOS'(sum);
    endfunction

    // Per-queue eligibility from registered occupancy, plus push/pop hits.
    always_comb begin
        for (int i = 0; i < FIFOS; i++) begin
            elig[i]     = (occ_r[i] != '0) && q_en[i];
            push_hit[i] = push && (push_fifo == LOG2_FIFOS'(i));
            pop_hit[i]  = pop && (pop_fifo == LOG2_FIFOS'(i));
        end
    end

    assign any_elig  = |elig;
    assign credit_ok = (CREDIT_W'(buf_cnt) + CREDIT_W'(inflight)) < CREDIT_W'(OUT_BUF_DEPTH);

    // Round-robin pick: continue the burst on cur, else scan from cur+1 with
    // cur itself checked last.
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        sel   = cur;
        stay  = 1'b0;
        found = 1'b0;
        if (elig[cur] && (burst_cnt < BURST_W'(BURST - 1))) begin
            stay = 1'b1;
        end else begin
            for (int k = 1; k <= FIFOS; k++) begin
                if (!found && elig[wrap_add(cur, k)]) begin
                    sel   = wrap_add(cur, k);
                    found = 1'b1;
                end
            end
        end
    end

    assign pop      = any_elig && credit_ok;
    assign pop_fifo = pop ? sel : '0;

    // Occupancy counters; a push and pop to the same queue cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFOS; i++) occ_r[i] <= '0;
        end else begin
            for (int i = 0; i < FIFOS; i++) begin
                case ({push_hit[i], pop_hit[i]})
                    2'b10:   occ_r[i] <= occ_r[i] + OCC_W'(1);
                    2'b01:   occ_r[i] <= occ_r[i] - OCC_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // Arbiter state moves only on an issued pop; idle with nothing eligible
    // ends any burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= '0;
            burst_cnt <= '0;
        end else if (pop) begin
            cur       <= sel;
            burst_cnt <= stay ? burst_cnt + BURST_W'(1) : '0;
        end else if (!any_elig) begin
            burst_cnt <= '0;
        end
    end

    // Remember which queue was popped so its read data can be tagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_fifo <= '0;
        end else begin
            inflight      <= pop;
            inflight_fifo <= pop_fifo;
        end
    end

    // Packed per-queue occupancy view.
    always_comb begin
        occ = '0;
        for (int i = 0; i < FIFOS; i++) begin
            occ[i*OCC_W +: OCC_W] = occ_r[i];
        end
    end

    assign out_valid = (buf_cnt != '0);

    llf_sched_out_buf #(
        .WIDTH (WIDTH),
        .ID_W  (LOG2_FIFOS)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (inflight),
        .wr_id     (inflight_fifo),
        .wr_data   (fifo_q),
        .rd        (out_valid && out_ready),
        .cnt       (buf_cnt),
        .head_data (out_data),
        .head_id   (out_fifo)
    );

endmodule

// File: tb/tb_linked_list_fifo_pop_scheduler.sv
// Bench for linked_list_fifo_pop_scheduler (FIFOS=4, BURST=2): directed
// scenarios plus a randomized phase, compared every cycle against a
// queue-based reference model that also plays the role of the FIFO.
module tb_linked_list_fifo_pop_scheduler;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int FIFOS = 4;
    localparam int BURST = 2;
    localparam int OCC_W = 6;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   push;
    logic [1:0]             push_fifo;
    logic [FIFOS-1:0]       q_en;
    logic                   pop;
    logic [1:0]             pop_fifo;
    logic [WIDTH-1:0]       fifo_q;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [1:0]             out_fifo;
    logic [FIFOS*OCC_W-1:0] occ;

    always #5 clk = ~clk;

    linked_list_fifo_pop_scheduler #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .FIFOS (FIFOS),
        .BURST (BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_fifo (push_fifo),
        .q_en      (q_en),
        .pop       (pop),
        .pop_fifo  (pop_fifo),
        .fifo_q    (fifo_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_fifo  (out_fifo),
        .occ       (occ)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    typedef struct {
        int         id;
        logic [7:0] data;
    } entry_t;

    int         m_occ [FIFOS];
    logic [7:0] m_store [FIFOS][$];
    entry_t     m_buf [$];
    bit         m_infl;
    int         m_infl_id;
    logic [7:0] m_fetch;
    int         m_cur;
    int         m_burst;

    // Observations from the most recent step.
    logic       obs_pop;
    logic [1:0] obs_pop_fifo;
    logic       obs_ov;
    logic [7:0] obs_od;
    logic [1:0] obs_of;
    logic [23:0] obs_occ;
    int         cyc;
    int         xfer_ids  [$];
    logic [7:0] xfer_data [$];
    int         xfer_cyc  [$];

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < FIFOS; i++) begin
            m_occ[i] = 0;
            m_store[i].delete();
        end
        m_buf.delete();
        m_infl    = 1'b0;
        m_infl_id = 0;
        m_fetch   = '0;
        m_cur     = 0;
        m_burst   = 0;
    endtask

    function automatic int model_total();
        int t = 0;
        for (int i = 0; i < FIFOS; i++) t += m_occ[i];
        return t;
    endfunction

    // One clock cycle: drive inputs, compare against the model mid-cycle,
    // advance the model, then play the FIFO's read data after the edge.
    task automatic step(input logic p, input int pf, input logic [7:0] pdata, input logic rdy);
        bit          elig [FIFOS];
        bit          any_e;
        bit          stay;
        bit          exp_pop;
        int          sel;
        logic [23:0] exp_occ;
        entry_t      e;
        push      = p;
        push_fifo = 2'(pf);
        out_ready = rdy;
        #2;
        any_e = 1'b0;
        for (int i = 0; i < FIFOS; i++) begin
            elig[i] = (m_occ[i] > 0) && q_en[i];
            any_e   = any_e | elig[i];
        end
        stay = elig[m_cur] && (m_burst < BURST - 1);
        sel  = m_cur;
        if (!stay) begin
            for (int k = 1; k <= FIFOS; k++) begin
                if (elig[(m_cur + k) % FIFOS]) begin
                    sel = (m_cur + k) % FIFOS;
                    break;
                end
            end
        end
        exp_pop = any_e && ((m_buf.size() + (m_infl ? 1 : 0)) < 3);
        exp_occ = '0;
        for (int i = 0; i < FIFOS; i++) exp_occ[i*OCC_W +: OCC_W] = 6'(m_occ[i]);

        check("pop", pop, exp_pop);
        check("pop_fifo", pop_fifo, exp_pop ? sel : 0);
        check("out_valid", out_valid, m_buf.size() != 0);
        if (m_buf.size() != 0) begin
            check("out_data", out_data, m_buf[0].data);
            check("out_fifo", out_fifo, m_buf[0].id);
        end else begin
            check("out_data_idle", out_data, 0);
            check("out_fifo_idle", out_fifo, 0);
        end
        check("occ", occ, exp_occ);

        obs_pop      = pop;
        obs_pop_fifo = pop_fifo;
        obs_ov       = out_valid;
        obs_od       = out_data;
        obs_of       = out_fifo;
        obs_occ      = occ;
        if (out_valid && out_ready) begin
            xfer_ids.push_back(int'(out_fifo));
            xfer_data.push_back(out_data);
            xfer_cyc.push_back(cyc);
        end

        if (m_buf.size() != 0 && rdy) void'(m_buf.pop_front());
        if (m_infl) begin
            e.id   = m_infl_id;
            e.data = m_fetch;
            m_buf.push_back(e);
        end
        if (exp_pop) begin
            m_occ[sel]--;
            m_fetch = m_store[sel].pop_front();
            m_cur   = sel;
            m_burst = stay ? m_burst + 1 : 0;
        end else if (!any_e) begin
            m_burst = 0;
        end
        m_infl    = exp_pop;
        m_infl_id = sel;
        if (p) begin
            m_occ[pf]++;
            m_store[pf].push_back(pdata);
        end

        @(posedge clk);
        #1;
        cyc++;
        fifo_q = m_infl ? m_fetch : 8'($urandom);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 0, 8'h00, rdy);
    endtask

    task automatic clear_xfers();
        xfer_ids.delete();
        xfer_data.delete();
        xfer_cyc.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t1_ids [6];
        int         t1_pf  [6];
        logic [7:0] t3_data [8];
        int         stall_pops;
        int         q0_served;

        t1_pf  = '{0, 0, 2, 2, 0, 2};
        t1_ids = '{0, 0, 2, 2, 0, 2};

        rst_n     = 1'b0;
        push      = 1'b0;
        push_fifo = '0;
        q_en      = 4'hF;
        out_ready = 1'b0;
        fifo_q    = '0;
        cyc       = 0;
        model_reset();

        // Reset values.
        #7;
        check("rst_pop", pop, 0);
        check("rst_pop_fifo", pop_fifo, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_fifo", out_fifo, 0);
        check("rst_occ", occ, 0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin with burst 2 across q0 and q2.
        clear_xfers();
        for (int i = 0; i < 6; i++) step(1'b1, t1_pf[i], 8'($urandom), 1'b1);
        idle(10, 1'b1);
        check("t1_xfer_count", xfer_ids.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < xfer_ids.size()) check("t1_order", xfer_ids[i], t1_ids[i]);
        end
        check("t1_occ_empty", occ, 0);

        // Single push latency.
        step(1'b1, 1, 8'hA5, 1'b1);
        check("t2_no_pop_on_push_cycle", obs_pop, 0);
        idle(1, 1'b1);
        check("t2_pop", obs_pop, 1);
        check("t2_pop_fifo", obs_pop_fifo, 1);
        idle(1, 1'b1);
        check("t2_not_yet_valid", obs_ov, 0);
        idle(1, 1'b1);
        check("t2_out_valid", obs_ov, 1);
        check("t2_out_data", obs_od, 8'hA5);
        check("t2_out_fifo", obs_of, 1);
        idle(3, 1'b1);

        // Stall: only three entries outstanding, then in-order gapless drain.
        clear_xfers();
        stall_pops = 0;
        for (int i = 0; i < 8; i++) begin
            t3_data[i] = 8'($urandom);
            step(1'b1, 3, t3_data[i], 1'b0);
            stall_pops += int'(obs_pop);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 0, 8'h00, 1'b0);
            stall_pops += int'(obs_pop);
        end
        check("t3_stall_pops", stall_pops, 3);
        check("t3_pop_held_off", obs_pop, 0);
        check("t3_no_xfer_stalled", xfer_ids.size(), 0);
        idle(16, 1'b1);
        check("t3_xfer_count", xfer_data.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < xfer_data.size()) begin
                check("t3_data_order", xfer_data[i], t3_data[i]);
                check("t3_no_gap", xfer_cyc[i] - xfer_cyc[0], i);
            end
        end

        // Same-cycle push and pop on q0 with occ[0]=2.
        q_en = 4'b1110;
        step(1'b1, 0, 8'($urandom), 1'b1);
        step(1'b1, 0, 8'($urandom), 1'b1);
        q_en = 4'b1111;
        step(1'b1, 0, 8'($urandom), 1'b1);
        check("t4_occ_before", obs_occ[OCC_W-1:0], 2);
        check("t4_pop_q0", obs_pop, 1);
        idle(1, 1'b1);
        check("t4_occ_kept", obs_occ[OCC_W-1:0], 2);
        idle(8, 1'b1);

        // Queue enable masking.
        clear_xfers();
        q_en = 4'b0010;
        for (int i = 0; i < 3; i++) step(1'b1, 0, 8'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1, 8'($urandom), 1'b1);
        idle(8, 1'b1);
        q0_served = 0;
        foreach (xfer_ids[i]) if (xfer_ids[i] == 0) q0_served++;
        check("t5_masked_q0_not_served", q0_served, 0);
        check("t5_q1_served", xfer_ids.size(), 3);
        check("t5_q0_occ", obs_occ[OCC_W-1:0], 3);
        q_en = 4'b0011;
        idle(10, 1'b1);
        check("t5_all_served", xfer_ids.size(), 6);
        check("t5_occ_empty", obs_occ, 0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic p;
            if (n % 37 == 0) q_en = 4'($urandom);
            p = ($urandom_range(0, 99) < 60) && (model_total() < DEPTH - FIFOS);
            step(p, int'($urandom_range(0, FIFOS - 1)), 8'($urandom), $urandom_range(0, 99) < 70);
        end
        q_en = 4'hF;
        idle(45, 1'b1);
        check("rand_drained", obs_occ, 0);

        // Reset mid-stream with two entries buffered.
        step(1'b1, 1, 8'($urandom), 1'b0);
        step(1'b1, 1, 8'($urandom), 1'b0);
        idle(3, 1'b0);
        check("t6_buffered_before_reset", obs_ov, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_occ", occ, 0);
        check("t6_rst_pop", pop, 0);
        check("t6_rst_out_data", out_data, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        fifo_q = 8'($urandom);
        idle(5, 1'b1);
        step(1'b1, 2, 8'h3C, 1'b1);
        idle(4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
